// File: rtl/omsp_hmac_arbiter.sv
// omsp_hmac_arbiter
// Lends the single HMAC core to one of two sequencers at a time. Each owner
// keeps the core for a whole session. Sessions are granted round-robin, and
// the core is held in reset between owners so that no key or partial MAC
// carries over from one owner to the next.
module omsp_hmac_arbiter #(
  parameter int unsigned SCRUB_CYCLES = 2  // 1..15 cycles of core reset after a session
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_req,
  output logic        req0_gnt,
  input  logic        req0_hmac_reset,
  input  logic        req0_start_continue,
  input  logic        req0_data_available,
  input  logic        req0_data_is_long,
  input  logic [15:0] req0_data,
  output logic        req0_busy,
  output logic [15:0] req0_hmac_out,

  input  logic        req1_req,
  output logic        req1_gnt,
  input  logic        req1_hmac_reset,
  input  logic        req1_start_continue,
  input  logic        req1_data_available,
  input  logic        req1_data_is_long,
  input  logic [15:0] req1_data,
  output logic        req1_busy,
  output logic [15:0] req1_hmac_out,

  output logic        hmac_reset,
  output logic        hmac_start_continue,
  output logic        hmac_data_available,
  output logic        hmac_data_is_long,
  output logic [15:0] hmac_data_in,
  input  logic        hmac_busy,
  input  logic [15:0] hmac_out,

  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    SCRUB = 2'd3
  } state_t;

  // Counter runs SCRUB_CYCLES-1 down to 0, giving SCRUB_CYCLES cycles in SCRUB.
  localparam logic [3:0] SCRUB_LOAD = 4'(SCRUB_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last_owner;
  logic       w_next_last_owner;
  logic [3:0] r_scrub_cnt;
  logic [3:0] w_next_scrub_cnt;

  // State register; last_owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_scrub_cnt  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would let later lines see updated state.
      r_state      <= w_next_state;
      r_last_owner <= w_next_last_owner;
      r_scrub_cnt  <= w_next_scrub_cnt;
    end
  end

  // Next-state: arbitrate in IDLE, hold the owner until it drops req, then scrub.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state      = r_state;
    w_next_last_owner = r_last_owner;
    w_next_scrub_cnt  = r_scrub_cnt;
    case (r_state)
      IDLE: begin
        if (req0_req && req1_req) begin
          w_next_state = r_last_owner ? OWN0 : OWN1;
        end else if (req0_req) begin
          w_next_state = OWN0;
        end else if (req1_req) begin
          w_next_state = OWN1;
        end
      end
      OWN0: begin
        if (!req0_req) begin
          w_next_state      = SCRUB;
          w_next_last_owner = 1'b0;
          w_next_scrub_cnt  = SCRUB_LOAD;
        end
      end
      OWN1: begin
        if (!req1_req) begin
          w_next_state      = SCRUB;
          w_next_last_owner = 1'b1;
          w_next_scrub_cnt  = SCRUB_LOAD;
        end
      end
      SCRUB: begin
        if (r_scrub_cnt == 4'd0) begin
          w_next_state = IDLE;
        end else begin
          w_next_scrub_cnt = r_scrub_cnt - 4'd1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output mux: purely a decode of the registered state; core idles in reset otherwise.
  always_comb begin
    req0_gnt            = 1'b0;
    req1_gnt            = 1'b0;
    req0_busy           = 1'b1;
    req1_busy           = 1'b1;
    req0_hmac_out       = 16'h0000;
    req1_hmac_out       = 16'h0000;
    hmac_reset          = 1'b1;
    hmac_start_continue = 1'b0;
    hmac_data_available = 1'b0;
    hmac_data_is_long   = 1'b0;
    hmac_data_in        = 16'h0000;
    owner               = 2'b00;
    case (r_state)
      OWN0: begin
        req0_gnt            = 1'b1;
        owner               = 2'b01;
        req0_busy           = hmac_busy;
        req0_hmac_out       = hmac_out;
        hmac_reset          = req0_hmac_reset;
        // Strobes are gated with req so nothing reaches the core as the session ends.
        hmac_start_continue = req0_start_continue & req0_req;
        hmac_data_available = req0_data_available & req0_req;
        hmac_data_is_long   = req0_data_is_long;
        hmac_data_in        = req0_data;
      end
      OWN1: begin
        req1_gnt            = 1'b1;
        owner               = 2'b10;
        req1_busy           = hmac_busy;
        req1_hmac_out       = hmac_out;
        hmac_reset          = req1_hmac_reset;
        hmac_start_continue = req1_start_continue & req1_req;
        hmac_data_available = req1_data_available & req1_req;
        hmac_data_is_long   = req1_data_is_long;
        hmac_data_in        = req1_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// Testbench for omsp_hmac_arbiter: directed scenarios plus randomized traffic,
// all compared against a session-level reference model (owner / last owner /
// remaining reset gap) kept in plain integers.
module tb_omsp_hmac_arbiter;

  logic        clk;
  logic        reset;
  logic        req   [2];
  logic        hrst  [2];
  logic        sc    [2];
  logic        da    [2];
  logic        dl    [2];
  logic [15:0] data  [2];
  logic        hmac_busy;
  logic [15:0] hmac_out;

  logic        gnt   [2];
  logic        busy  [2];
  logic [15:0] hout  [2];
  logic        c_rst, c_sc, c_da, c_dl;
  logic [15:0] c_data;
  logic [1:0]  owner;

  logic        g15   [2];
  logic        b15   [2];
  logic [15:0] o15   [2];
  logic        c15_rst, c15_sc, c15_da, c15_dl;
  logic [15:0] c15_data;
  logic [1:0]  owner15;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner (-1 none), last owner, cycles of reset gap left.
  int m_owner;
  int m_last;
  int m_gap;
  localparam int MODEL_SCRUB = 2;

  omsp_hmac_arbiter #(.SCRUB_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0_req(req[0]), .req0_gnt(gnt[0]), .req0_hmac_reset(hrst[0]),
    .req0_start_continue(sc[0]), .req0_data_available(da[0]),
    .req0_data_is_long(dl[0]), .req0_data(data[0]),
    .req0_busy(busy[0]), .req0_hmac_out(hout[0]),
    .req1_req(req[1]), .req1_gnt(gnt[1]), .req1_hmac_reset(hrst[1]),
    .req1_start_continue(sc[1]), .req1_data_available(da[1]),
    .req1_data_is_long(dl[1]), .req1_data(data[1]),
    .req1_busy(busy[1]), .req1_hmac_out(hout[1]),
    .hmac_reset(c_rst), .hmac_start_continue(c_sc),
    .hmac_data_available(c_da), .hmac_data_is_long(c_dl),
    .hmac_data_in(c_data), .hmac_busy(hmac_busy), .hmac_out(hmac_out),
    .owner(owner)
  );

  omsp_hmac_arbiter #(.SCRUB_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset),
    .req0_req(req[0]), .req0_gnt(g15[0]), .req0_hmac_reset(hrst[0]),
    .req0_start_continue(sc[0]), .req0_data_available(da[0]),
    .req0_data_is_long(dl[0]), .req0_data(data[0]),
    .req0_busy(b15[0]), .req0_hmac_out(o15[0]),
    .req1_req(req[1]), .req1_gnt(g15[1]), .req1_hmac_reset(hrst[1]),
    .req1_start_continue(sc[1]), .req1_data_available(da[1]),
    .req1_data_is_long(dl[1]), .req1_data(data[1]),
    .req1_busy(b15[1]), .req1_hmac_out(o15[1]),
    .hmac_reset(c15_rst), .hmac_start_continue(c15_sc),
    .hmac_data_available(c15_da), .hmac_data_is_long(c15_dl),
    .hmac_data_in(c15_data), .hmac_busy(hmac_busy), .hmac_out(hmac_out),
    .owner(owner15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [57:0] act_vec;
  assign act_vec = {gnt[0], gnt[1], busy[0], busy[1], hout[0], hout[1],
                    c_rst, c_sc, c_da, c_dl, c_data, owner};

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_gap   = 0;
  endfunction

  // One clock edge of session-level behaviour, using the inputs held before the edge.
  function automatic void model_tick();
    if (reset) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = MODEL_SCRUB;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (req[0] && req[1]) begin
      m_owner = 1 - m_last;
    end else if (req[0]) begin
      m_owner = 0;
    end else if (req[1]) begin
      m_owner = 1;
    end
  endfunction

  // Expected outputs of the SCRUB_CYCLES=2 instance for the current model state and inputs.
  function automatic logic [57:0] exp_vec();
    logic        g0 = 1'b0, g1 = 1'b0, b0 = 1'b1, b1 = 1'b1;
    logic [15:0] o0 = 16'h0, o1 = 16'h0, dat = 16'h0;
    logic        r = 1'b1, s = 1'b0, d = 1'b0, l = 1'b0;
    logic [1:0]  own = 2'b00;
    if (m_owner == 0) begin
      g0 = 1'b1; b0 = hmac_busy; o0 = hmac_out; own = 2'b01;
      r = hrst[0]; s = sc[0] & req[0]; d = da[0] & req[0]; l = dl[0]; dat = data[0];
    end else if (m_owner == 1) begin
      g1 = 1'b1; b1 = hmac_busy; o1 = hmac_out; own = 2'b10;
      r = hrst[1]; s = sc[1] & req[1]; d = da[1] & req[1]; l = dl[1]; dat = data[1];
    end
    return {g0, g1, b0, b1, o0, o1, r, s, d, l, dat, own};
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      hrst[i] = 1'b0; sc[i] = 1'b0; da[i] = 1'b0; dl[i] = 1'b0; data[i] = 16'h0;
    end
    hmac_busy = 1'b0;
    hmac_out  = 16'h0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      hrst[i] = 1'($urandom); sc[i] = 1'($urandom); da[i] = 1'($urandom);
      dl[i]   = 1'($urandom); data[i] = 16'($urandom);
    end
    hmac_busy = 1'($urandom);
    hmac_out  = 16'($urandom);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1;
    rand_inputs();
    model_reset();
    #12;
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", act_vec, exp_vec());
    end
    checks++;
    if (c_rst !== 1'b1 || owner !== 2'b00 || busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_core: hmac_reset %b owner %b busy %b%b expected 1 00 11",
               c_rst, owner, busy[0], busy[1]);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    clk_edge();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00 || gnt[0] !== 1'b0 || gnt[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: owner %b gnt %b%b expected 00 00", owner, gnt[0], gnt[1]);
    end
  endtask

  task automatic test_grant_data();
    clk_edge();
    req[0]   = 1'b1;
    hmac_out = 16'h1234;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b0) begin
      errors++;
      $display("FAIL grant_early: gnt0 %b expected 0", gnt[0]);
    end
    clk_edge();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b1 || owner !== 2'b01) begin
      errors++;
      $display("FAIL grant_latency: gnt0 %b owner %b expected 1 01", gnt[0], owner);
    end
    clk_edge();
    data[0] = 16'hA55A;
    da[0]   = 1'b1;
    @(negedge clk);
    checks++;
    if (c_data !== 16'hA55A || c_da !== 1'b1 || hout[1] !== 16'h0000 || hout[0] !== 16'h1234) begin
      errors++;
      $display("FAIL data_path: data %h avail %b out1 %h out0 %h expected a55a 1 0000 1234",
               c_data, c_da, hout[1], hout[0]);
    end
    clk_edge();
    da[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (c_da !== 1'b0 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL data_pulse: got %h expected %h", act_vec, exp_vec());
    end
    clk_edge();
    req[0] = 1'b0;
    clk_edge();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b0 || c_rst !== 1'b1) begin
      errors++;
      $display("FAIL release: gnt0 %b hmac_reset %b expected 0 1", gnt[0], c_rst);
    end
    for (int i = 0; i < 3; i++) clk_edge();
  endtask

  task automatic test_tie();
    int n;
    reset_pulse();
    req[0] = 1'b1; req[1] = 1'b1;
    clk_edge();
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b1 || gnt[1] !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: gnt %b%b expected 10", gnt[0], gnt[1]);
    end
    clk_edge();
    req[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL tie_handover: got %h expected %h", act_vec, exp_vec());
      end
      if (gnt[1]) break;
      if (c_rst) n++;
    end
    checks++;
    if (gnt[1] !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL tie_gap: gnt1 %b reset cycles %0d expected 1 3", gnt[1], n);
    end
    clk_edge();
    req[1] = 1'b0;
    clk_edge();
    req[0] = 1'b1; req[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      @(negedge clk);
      if (gnt[0] || gnt[1]) break;
    end
    checks++;
    if (gnt[0] !== 1'b1 || gnt[1] !== 1'b0) begin
      errors++;
      $display("FAIL tie_second: gnt %b%b expected 10", gnt[0], gnt[1]);
    end
  endtask

  task automatic test_drop_strobe();
    clk_edge();
    req[1] = 1'b0;
    req[0] = 1'b0;
    sc[0]  = 1'b1;
    da[0]  = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt[0] !== 1'b1 || c_sc !== 1'b0 || c_da !== 1'b0) begin
      errors++;
      $display("FAIL drop_strobe: gnt0 %b start %b avail %b expected 1 0 0", gnt[0], c_sc, c_da);
    end
    clk_edge();
    sc[0] = 1'b0;
    da[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (c_rst !== 1'b1 || owner !== 2'b00 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL drop_scrub: got %h expected %h", act_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) clk_edge();
  endtask

  task automatic test_async_reset();
    req[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      @(negedge clk);
      if (gnt[0]) break;
    end
    checks++;
    if (gnt[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_grant: gnt0 %b expected 1", gnt[0]);
    end
    clk_edge();
    hmac_busy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt[0] !== 1'b0 || c_rst !== 1'b1 || busy[0] !== 1'b1 || busy[1] !== 1'b1 || owner !== 2'b00) begin
      errors++;
      $display("FAIL areset_mid: gnt0 %b hmac_reset %b busy %b%b owner %b expected 0 1 11 00",
               gnt[0], c_rst, busy[0], busy[1], owner);
    end
    model_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (owner !== 2'b00 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL areset_release: got %h expected %h", act_vec, exp_vec());
    end
    clk_edge();
    @(negedge clk);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL areset_regrant: got %h expected %h", act_vec, exp_vec());
    end
    hmac_busy = 1'b0;
  endtask

  task automatic test_starvation();
    int n;
    req[0] = 1'b0;
    req[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      @(negedge clk);
      if (gnt[1]) break;
    end
    checks++;
    if (gnt[1] !== 1'b1) begin
      errors++;
      $display("FAIL starve_grant: gnt1 %b expected 1", gnt[1]);
    end
    for (int i = 0; i < 100; i++) begin
      clk_edge();
      req[0] = 1'($urandom);
      rand_inputs();
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec() || gnt[1] !== 1'b1 || gnt[0] !== 1'b0) begin
        errors++;
        $display("FAIL starve_hold cycle %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    clk_edge();
    idle_inputs();
    req[1] = 1'b0;
    req[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      clk_edge();
      n++;
      @(negedge clk);
      if (gnt[0]) break;
    end
    checks++;
    if (gnt[0] !== 1'b1 || n != 4) begin
      errors++;
      $display("FAIL starve_after: gnt0 %b edges %0d expected 1 4", gnt[0], n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clk_edge();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
      rand_inputs();
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_scrub15();
    int n;
    clk_edge();
    idle_inputs();
    req[0] = 1'b1; req[1] = 1'b0;
    reset_pulse();
    clk_edge();
    @(negedge clk);
    checks++;
    if (g15[0] !== 1'b1 || owner15 !== 2'b01) begin
      errors++;
      $display("FAIL scrub15_grant: gnt0 %b owner %b expected 1 01", g15[0], owner15);
    end
    clk_edge();
    req[0] = 1'b0;
    req[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      clk_edge();
      @(negedge clk);
      if (g15[1]) break;
      if (c15_rst && !g15[0]) n++;
    end
    checks++;
    if (g15[1] !== 1'b1 || n != 16) begin
      errors++;
      $display("FAIL scrub15_gap: gnt1 %b reset cycles %0d expected 1 16", g15[1], n);
    end
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL scrub15_main: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  initial begin
    idle_inputs();
    req[0] = 1'b0;
    req[1] = 1'b0;
    test_reset();
    test_grant_data();
    test_tie();
    test_drop_strobe();
    test_async_reset();
    test_starvation();
    test_random();
    test_scrub15();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/omsp_hmac_arbiter.md
# omsp_hmac_arbiter

Shares the single HMAC core between two HMAC sequencers: requester 0 is the Sancus crypto-instruction controller, requester 1 is the key-derivation/attestation engine. Each requester holds the core for a whole session. Grants are round-robin between sessions. Between owners the core is held in reset, so internal state (key, partial MAC) never carries over. Sits between the sequencers and the HMAC core, inside the Sancus crypto unit.

## Interface
Parameters:
- SCRUB_CYCLES, default 2: cycles the core `hmac_reset` is held after a session ends. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- reqN_req  in  1  requester N (N=0,1) wants or holds the core; level, held for the whole session
- reqN_gnt  out  1  requester N owns the core
- reqN_hmac_reset  in  1  requester's core reset request
- reqN_start_continue  in  1  requester's start/continue strobe
- reqN_data_available  in  1  requester's data strobe
- reqN_data_is_long  in  1  requester's long-data flag
- reqN_data  in  16  requester's data word
- reqN_busy  out  1  core busy as seen by requester N
- reqN_hmac_out  out  16  core output as seen by requester N
- hmac_reset  out  1  to core
- hmac_start_continue  out  1  to core
- hmac_data_available  out  1  to core
- hmac_data_is_long  out  1  to core
- hmac_data_in  out  16  to core
- hmac_busy  in  1  from core
- hmac_out  in  16  from core
- owner  out  2  one-hot current owner; 00 = none

## Operation
- State registers: state in {IDLE, OWN0, OWN1, SCRUB}, last_owner (1 bit), scrub_cnt (4 bits).
- IDLE:
  - Core outputs: hmac_reset=1, strobes 0, data 0, data_is_long 0.
  - Only req0 high: go to OWN0. Only req1 high: go to OWN1.
  - Both high: grant the requester that is not last_owner.
- OWNx:
  - reqx_gnt = 1 and owner one-hot for x, both decoded from state.
  - The core is driven by requester x. Strobes are additionally gated with reqx_req, so no strobe reaches the core in the cycle req drops.
  - reqx_busy = hmac_busy; reqx_hmac_out = hmac_out.
  - When reqx_req = 0: go to SCRUB, set last_owner = x, load scrub_cnt = SCRUB_CYCLES-1.
- SCRUB:
  - hmac_reset = 1, strobes 0.
  - Decrement scrub_cnt; go to IDLE when it reaches 0, regardless of hmac_busy or pending requests.
- Non-owner requester: gnt 0, busy 1, hmac_out 16'h0000. Core output never reaches a non-owner.
- The owner is never preempted. A requester that never drops req starves the other; this is by design, and session bounds are the sequencers' responsibility.
- A requester whose req rises during SCRUB or during the other's session waits. It is not latched: if req drops before the grant, the request is lost.

## Timing
- Reset (async):
  - state=IDLE, last_owner=1 (req0 wins the first tie), scrub_cnt=0.
  - Outputs during and after reset: gnt 0, owner 00, hmac_reset 1, strobes 0, hmac_data_in 0, busy 1 on both sides, hmac_out 0 on both sides.
- Grant latency: req sampled high at edge k while in IDLE → gnt high from edge k (the registered state), i.e. first owned cycle is k..k+1. Requesters must not strobe before seeing gnt.
- Release: req low in cycle c → gnt low after edge c. hmac_reset is high for exactly SCRUB_CYCLES cycles, then 1 cycle of IDLE (also hmac_reset high).
- Minimum gap between two sessions: SCRUB_CYCLES+1 cycles of hmac_reset.
- Reset mid-session: gnt drops asynchronously and the core is reset; requesters see busy=1.
- Both requesters rising in the same IDLE cycle is resolved by last_owner only; no other priority.
- Muxing is purely combinational on state; there is no added latency on data or strobes.

## Test plan
- After reset, req0=1: gnt0 after 1 edge, owner=01. reqN_data=16'hA55A with data_available pulse → core sees 16'hA55A and a 1-cycle pulse. req1_hmac_out=0 while hmac_out=16'h1234.
- Both req rise together after reset → req0 granted. req0 drops → hmac_reset high for SCRUB_CYCLES=2 cycles plus 1 IDLE cycle, then gnt1. Next tie → req0.
- Owner drops req in the same cycle it pulses start_continue → no strobe reaches the core; SCRUB entered.
- Async reset asserted mid-session with hmac_busy=1 → gnt0=0 immediately, hmac_reset=1, both busy=1, state IDLE after reset release.
- req1 held continuously for 100 cycles while req0 pulses → req0 never granted and req1 never interrupted. After req1 drops, req0 (if still high) granted after scrub.
- SCRUB_CYCLES=15: hmac_reset held for exactly 16 cycles between sessions; scrub_cnt does not wrap.
